spi_frame_arbiter: RTL

- Shares one byte-level SPI engine (start/data_in/busy/new_data/data_out) between NREQ requesters, e.g. the 8-digit LED driver and a second SPI peripheral.
- Grants whole frames (multi-byte, chip-select-bounded transfers) round-robin.
- Drives one active-low chip select per requester with programmable setup, hold and inter-frame gap.
- Routes received bytes back to the frame owner.

---
 rtl/spi_frame_arbiter.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_arbiter.sv
// ---------------------------------------------------------------------------
// spi_frame_arbiter
//
// Shares a single byte-level SPI engine between NREQ requesters. Whole frames
// (chip-select-bounded, multi-byte transfers) are granted round-robin. Each
// requester has its own active-low chip select, framed by programmable setup,
// hold and inter-frame gap times. Bytes received by the engine are routed back
// to the current frame owner.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort frames whose owner
// stalls for TIMEOUT_CYC cycles between bytes (sticky timeout_err).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (engine shares it)
//   req_valid[i]      requester i offers a byte
//   req_data[8i+:8]   byte from requester i
//   req_last[i]       byte is the final one of the frame
//   req_ready[i]      byte accepted when req_valid[i] & req_ready[i]
//   grant[i]          one-hot frame owner, 0 when idle
//   done[i]           1-cycle pulse as cs_n[i] rises at the end of a frame
//   rsp_valid[i]      1-cycle pulse: rsp_data holds a byte for owner i
//   rsp_data          received byte
//   cs_n[i]           active-low chip select per requester
//   spi_start         engine start pulse
//   spi_data          engine data_in, held from start until busy falls
//   spi_busy          engine busy
//   spi_new_data      engine received-byte strobe
//   spi_rdata         engine data_out
//   timeout_err       sticky frame-abort flag (0 unless SPI_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module spi_frame_arbiter #(
  parameter int NREQ         = 2,
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_HOLD_CYC  = 4,
  parameter int CS_GAP_CYC   = 8,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [NREQ-1:0]   cs_n,
  output logic              spi_start,
  output logic [7:0]        spi_data,
  input  logic              spi_busy,
  input  logic              spi_new_data,
  input  logic [7:0]        spi_rdata,
  output logic              timeout_err
);

  localparam int PW = $clog2(NREQ);

  // Counters reload with N-1 and exit at zero, so a state lasts N cycles;
  // N = 0 collapses to a single cycle.
  function automatic logic [15:0] reload_val(input int cyc);
    return (cyc <= 1) ? 16'd0 : 16'(cyc - 1);
  endfunction

  localparam logic [15:0] SETUP_LD = reload_val(CS_SETUP_CYC);
  localparam logic [15:0] HOLD_LD  = reload_val(CS_HOLD_CYC);
  localparam logic [15:0] GAP_LD   = reload_val(CS_GAP_CYC);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("spi_frame_arbiter: NREQ must be 2..4 and TIMEOUT_CYC 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;      // last winner; also the owner index while granted
  logic [NREQ-1:0]   cs_n_q, cs_n_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              first_q, first_d;  // marks the first WAIT cycle
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [7:0]        rsp_data_q;

  logic [PW-1:0]     pick;
  logic [PW-1:0]     cand;
  logic              found;
  logic [7:0]        owner_data;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0]       stall_q, stall_d;
  logic              terr_q, terr_d;
`endif

  // Round-robin search starting just after the previous winner.
  // NOTE: every signal assigned in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (ptr_q == PW'(i)) owner_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cs_n_d    = cs_n_q;
    data_d    = data_q;
    last_d    = last_q;
    first_d   = 1'b0;
    done_d    = '0;
    req_ready = '0;
    spi_start = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    stall_d   = '0;
    terr_d    = terr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d = NREQ'(1) << pick;
          ptr_d   = pick;
          cs_n_d  = ~(NREQ'(1) << pick);
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == 16'd0) state_d = S_ISSUE;
        else                cnt_d   = cnt_q - 16'd1;
      end

      S_ISSUE: begin
        req_ready[ptr_q] = 1'b1;
        if (req_valid[ptr_q]) begin
          spi_start = 1'b1;
          data_d    = owner_data;
          last_d    = req_last[ptr_q];
          first_d   = 1'b1;
          state_d   = S_WAIT;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (stall_q == STALL_LIMIT) begin
          // Owner stalled too long: close the frame through the normal hold.
          terr_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end

      S_WAIT: begin
        // busy only rises the cycle after start, so the first WAIT cycle
        // would otherwise see a stale low.
        if (!first_q && !spi_busy) begin
          if (last_q) begin
            cnt_d   = HOLD_LD;
            state_d = S_HOLD;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == 16'd0) begin
          cs_n_d  = '1;
          done_d  = grant_q;
          grant_d = '0;
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      cs_n_q  <= '1;
      data_q  <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      last_q  <= last_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  // Receive path: a byte arriving while nobody owns the bus is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= spi_new_data ? grant_q : '0;
      if (spi_new_data && |grant_q) rsp_data_q <= spi_rdata;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  // The byte is presented combinationally in the start cycle so the engine
  // captures it on the same edge; the latched copy holds it afterwards.
  assign spi_data  = spi_start ? owner_data : data_q;
  assign grant     = grant_q;
  assign cs_n      = cs_n_q;
  assign done      = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
